// File: rtl/op2_shifter.sv
// rtl/op2_shifter.sv - iterative ARM register-shift operand-2 unit; define SHIFTER_FAST_EN for up to 4 steps per edge
module op2_shifter #(
  parameter int WordWidth = 32
) (
  input  logic                 in_Clk,
  input  logic                 in_Rst_N,
  input  logic                 in_Start,
  input  logic [WordWidth-1:0] in_Rm,
  input  logic [1:0]           in_ShiftType,
  input  logic [7:0]           in_ShiftAmt,
  input  logic                 in_Carry,
  output logic                 out_Busy,
  output logic                 out_Done,
  output logic [WordWidth-1:0] out_Op2,
  output logic                 out_ShifterCarry
);

  localparam int CW = $clog2(WordWidth + 2);
  localparam int AW = $clog2(WordWidth);
`ifdef SHIFTER_FAST_EN
  localparam int STEPS = 4;
`else
  localparam int STEPS = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [1:0]     shift_type;
  logic [CW-1:0]  start_n;
  logic [CW-1:0]  step_cnt;
  logic [WordWidth-1:0] step_op2;
  logic           step_c;
  logic [AW-1:0]  rot_amt;
  logic           start_ok;

  assign start_ok = in_Start && (state == S_IDLE || state == S_DONE);
  assign rot_amt  = in_ShiftAmt[AW-1:0];
  assign step_cnt = (cnt > CW'(STEPS)) ? CW'(STEPS) : cnt;

  // Step count: amounts past the point where the result saturates are clamped.
  always_comb begin
    start_n = '0;
    case (in_ShiftType)
      2'b00, 2'b01:
        start_n = (in_ShiftAmt > 8'(WordWidth + 1)) ? CW'(WordWidth + 1) : CW'(in_ShiftAmt);
      2'b10:
        start_n = (in_ShiftAmt > 8'(WordWidth)) ? CW'(WordWidth) : CW'(in_ShiftAmt);
      default:
        if (in_ShiftAmt == 8'd0)
          start_n = '0;
        else if (rot_amt == '0)
          start_n = CW'(WordWidth);
        else
          start_n = CW'(rot_amt);
    endcase
  end

  always_comb begin
    step_op2 = out_Op2;
    step_c   = out_ShifterCarry;
    for (int i = 0; i < STEPS; i++) begin
      if (CW'(i) < cnt) begin
        case (shift_type)
          2'b00: begin
            step_c   = step_op2[WordWidth-1];
            step_op2 = {step_op2[WordWidth-2:0], 1'b0};
          end
          2'b01: begin
            step_c   = step_op2[0];
            step_op2 = {1'b0, step_op2[WordWidth-1:1]};
          end
          2'b10: begin
            step_c   = step_op2[0];
            step_op2 = {step_op2[WordWidth-1], step_op2[WordWidth-1:1]};
          end
          default: begin
            step_c   = step_op2[0];
            step_op2 = {step_op2[0], step_op2[WordWidth-1:1]};
          end
        endcase
      end
    end
  end

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      state            <= S_IDLE;
      cnt              <= '0;
      shift_type       <= 2'b00;
      out_Op2          <= '0;
      out_ShifterCarry <= 1'b0;
      out_Busy         <= 1'b0;
      out_Done         <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          out_Op2          <= step_op2;
          out_ShifterCarry <= step_c;
          cnt              <= cnt - step_cnt;
          if (cnt <= CW'(STEPS)) begin
            state    <= S_DONE;
            out_Busy <= 1'b0;
            out_Done <= 1'b1;
          end
        end
        default: begin
          if (start_ok) begin
            out_Op2          <= in_Rm;
            out_ShifterCarry <= in_Carry;
            shift_type       <= in_ShiftType;
            cnt              <= start_n;
            if (start_n == '0) begin
              state    <= S_DONE;
              out_Busy <= 1'b0;
              out_Done <= 1'b1;
            end else begin
              state    <= S_SHIFT;
              out_Busy <= 1'b1;
              out_Done <= 1'b0;
            end
          end else begin
            state    <= S_IDLE;
            out_Busy <= 1'b0;
            out_Done <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
